// File: rtl/dflow_tuple_extractor.sv
// dflow_tuple_extractor: snoops the SBUS packet stream, captures the first
// 64 header bytes of each packet and emits one IPv4 5-tuple flow record per
// packet through a first-word-fall-through FIFO.
//   ACLK, ARESET         clock, synchronous active-high reset
//   S_SBUS_*             ingress beat (valid/data/keep/ctl), no backpressure
//   M_SBUS_*             registered 1-cycle copy of S_SBUS_*
//   M_TUPLE_VALID/READY  FIFO not-empty / consumer pop
//   M_TUPLE_DATA         {SIP, DIP, SPORT, DPORT, PROTO}
//   M_TUPLE_LEN          frame length in bytes (IP total length + L2 header)
//   M_TUPLE_FLAGS        {vlan, l4_valid, ip_opt, 1'b0}
//   DROP_CNT             saturating count of tuples lost to a full FIFO
module dflow_tuple_extractor #(
  parameter int TDATA_WIDTH = 256,
  parameter int FIFO_DEPTH  = 8,
  parameter int VLAN_EN     = 1
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic                     S_SBUS_VALID,
  input  logic [TDATA_WIDTH-1:0]   S_SBUS_TDATA,
  input  logic [TDATA_WIDTH/8-1:0] S_SBUS_TKEEP,
  input  logic [7:0]               S_SBUS_CTL,
  output logic                     M_SBUS_VALID,
  output logic [TDATA_WIDTH-1:0]   M_SBUS_TDATA,
  output logic [TDATA_WIDTH/8-1:0] M_SBUS_TKEEP,
  output logic [7:0]               M_SBUS_CTL,
  output logic                     M_TUPLE_VALID,
  input  logic                     M_TUPLE_READY,
  output logic [103:0]             M_TUPLE_DATA,
  output logic [16:0]              M_TUPLE_LEN,
  output logic [3:0]               M_TUPLE_FLAGS,
  output logic [31:0]              DROP_CNT
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int RW   = 104 + 17 + 4;
  localparam bit WIDE = (TDATA_WIDTH == 512);

  typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

  state_t         state, state_nxt;
  logic           cap0, cap1, commit_nxt, commit;
  logic [511:0]   hdr;

  // ---------------- passthrough ----------------
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      M_SBUS_VALID <= 1'b0;
      M_SBUS_TDATA <= '0;
      M_SBUS_TKEEP <= '0;
      M_SBUS_CTL   <= '0;
    end else begin
      M_SBUS_VALID <= S_SBUS_VALID;
      M_SBUS_TDATA <= S_SBUS_TDATA;
      M_SBUS_TKEEP <= S_SBUS_TKEEP;
      M_SBUS_CTL   <= S_SBUS_CTL;
    end
  end

  // ---------------- capture FSM ----------------
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state  <= IDLE;
      commit <= 1'b0;
    end else begin
      state  <= state_nxt;
      commit <= commit_nxt;
    end
  end

  // Any SOP restarts capture from whatever state we are in, which is what
  // makes an unterminated packet abort silently.
  always_comb begin
    state_nxt  = state;
    cap0       = 1'b0;
    cap1       = 1'b0;
    commit_nxt = 1'b0;
    if (S_SBUS_VALID) begin
      case (S_SBUS_CTL)
        8'hFF: begin
          cap0      = 1'b1;
          state_nxt = WIDE ? BODY : HDR;
        end
        8'h03: begin
          state_nxt = IDLE;
          if (WIDE) begin
            cap0       = 1'b1;
            commit_nxt = 1'b1;
          end
        end
        8'hFE: begin
          if (state == HDR) begin
            cap1      = 1'b1;
            state_nxt = BODY;
          end
        end
        8'h01: begin
          if (state == BODY) commit_nxt = 1'b1;
          state_nxt = IDLE;
        end
        default: ;
      endcase
    end
  end

  // The second-beat slice is only ever enabled at 256 bits; at 512 it is
  // harmlessly sized from the top of the beat.
  always_ff @(posedge ACLK) begin
    if (cap0) hdr[511 -: TDATA_WIDTH] <= S_SBUS_TDATA;
    if (cap1) hdr[255:0] <= S_SBUS_TDATA[TDATA_WIDTH-1 -: 256];
  end

  // ---------------- parser ----------------
  // A VLAN tag is removed by shifting the buffer left 4 bytes so every
  // field sits at its untagged position.
  logic           vlan, is_ipv4, l4, unused_hdr_bits;
  logic [511:0]   hdr_s;
  logic [3:0]     ihl;
  logic [7:0]     proto;
  logic [15:0]    tot_len;
  logic [16:0]    frame_len;
  logic [RW-1:0]  rec;

  assign vlan      = (VLAN_EN != 0) && (hdr[415:400] == 16'h8100);
  assign hdr_s     = vlan ? (hdr << 32) : hdr;
  assign is_ipv4   = (hdr_s[415:400] == 16'h0800);
  assign ihl       = hdr_s[395:392];
  assign tot_len   = hdr_s[383:368];
  assign proto     = hdr_s[327:320];
  assign l4        = ((proto == 8'd6) || (proto == 8'd17)) && (ihl == 4'd5);
  assign frame_len = {1'b0, tot_len} + (vlan ? 17'd18 : 17'd14);
  assign rec       = {hdr_s[303:272], hdr_s[271:240],
                      l4 ? hdr_s[239:224] : 16'h0000,
                      l4 ? hdr_s[223:208] : 16'h0000,
                      proto, frame_len,
                      vlan, l4, (ihl != 4'd5), 1'b0};
  assign unused_hdr_bits = ^hdr_s;

  // ---------------- tuple FIFO ----------------
  logic [RW-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic           empty, full, pop, push_req, push, drop;
  logic [31:0]    drop_cnt;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign pop      = !empty && M_TUPLE_READY;
  assign push_req = commit && is_ipv4;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (push) mem[wr_ptr] <= rec;
  end

  // Read data is masked while empty so the outputs are all-zero after reset.
  assign M_TUPLE_VALID = !empty;
  assign {M_TUPLE_DATA, M_TUPLE_LEN, M_TUPLE_FLAGS} = empty ? '0 : mem[rd_ptr];
  assign DROP_CNT      = drop_cnt;

endmodule
